// File: rtl/board_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : board_scrambler
//  Purpose  : Builds a solvable 4x4 sliding-puzzle board by applying a
//             programmable number of pseudo-random legal blank moves to the
//             solved board. The walk is driven by a 16-bit Galois LFSR.
//             A one-cycle o_start pulse announces the finished board.
//  Options  : SCRAMBLER_NO_UNDO_EN - reject a move that undoes the previous
//             legal move (the attempt still consumes one LFSR step).
//  Revision : 1.0 - initial release
// ============================================================================
module board_scrambler #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_MOVES_W = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [MAX_MOVES_W-1:0]       i_num_moves,
  input  logic                         i_seed_load,
  input  logic [15:0]                  i_seed,
  output logic [3:0][3:0][3:0]         o_klotski,
  output logic [1:0]                   o_blank_row,
  output logic [1:0]                   o_blank_col,
  output logic                         o_busy,
  output logic                         o_start
);

  localparam logic [15:0] c_lfsr_mask = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [3:0][3:0][3:0]     board_q;
  logic [1:0]               blank_row_q;
  logic [1:0]               blank_col_q;
  logic [15:0]              lfsr_q;
  logic [MAX_MOVES_W-1:0]   cnt_q;
  logic [MAX_MOVES_W-1:0]   target_q;
  logic                     busy_q;
  logic                     start_q;
`ifdef SCRAMBLER_NO_UNDO_EN
  logic                     prev_valid_q;
  logic [1:0]               prev_dir_q;
`endif

  logic [1:0]               dir_d;
  logic [15:0]              lfsr_d;
  logic [1:0]               nbr_row_d;
  logic [1:0]               nbr_col_d;
  logic                     legal_d;
  logic [MAX_MOVES_W-1:0]   cnt_d;

  // Storage index [i][j] holds display (3-i, 3-j); the solved value there is
  // 16-4i-j, which wraps to 0 (the blank) at [0][0].
  function automatic logic [3:0][3:0][3:0] solved_board();
    logic [3:0][3:0][3:0] b;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[i][j] = 4'(16 - 4 * i - j);
      end
    end
    return b;
  endfunction

  // Decode the current attempt: direction, neighbour square, legality, next LFSR.
  always_comb begin
    dir_d     = lfsr_q[1:0];
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_lfsr_mask : 16'h0000);
    nbr_row_d = blank_row_q;
    nbr_col_d = blank_col_q;
    legal_d   = 1'b0;
    cnt_d     = cnt_q + 1'b1;
    case (dir_d)
      2'd0: if (blank_row_q != 2'd0) begin legal_d = 1'b1; nbr_row_d = blank_row_q - 2'd1; end
      2'd1: if (blank_row_q != 2'd3) begin legal_d = 1'b1; nbr_row_d = blank_row_q + 2'd1; end
      2'd2: if (blank_col_q != 2'd0) begin legal_d = 1'b1; nbr_col_d = blank_col_q - 2'd1; end
      default: if (blank_col_q != 2'd3) begin legal_d = 1'b1; nbr_col_d = blank_col_q + 2'd1; end
    endcase
`ifdef SCRAMBLER_NO_UNDO_EN
    // Inverse directions differ only in bit 0 (up/down, left/right).
    if (prev_valid_q && (dir_d == (prev_dir_q ^ 2'b01))) begin
      legal_d = 1'b0;
    end
`endif
  end

  // Control FSM with registered board, blank position and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      board_q      <= solved_board();
      blank_row_q  <= 2'd3;
      blank_col_q  <= 2'd3;
      lfsr_q       <= LFSR_SEED;
      cnt_q        <= '0;
      target_q     <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
`ifdef SCRAMBLER_NO_UNDO_EN
      prev_valid_q <= 1'b0;
      prev_dir_q   <= 2'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          start_q <= 1'b0;
          if (i_seed_load) begin
            // A zero seed would lock the LFSR at zero forever.
            lfsr_q <= (i_seed == 16'h0000) ? LFSR_SEED : i_seed;
          end
          if (i_start) begin
            target_q     <= i_num_moves;
            board_q      <= solved_board();
            blank_row_q  <= 2'd3;
            blank_col_q  <= 2'd3;
            cnt_q        <= '0;
`ifdef SCRAMBLER_NO_UNDO_EN
            prev_valid_q <= 1'b0;
`endif
            if (i_num_moves != '0) begin
              state_q <= S_MOVE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              start_q <= 1'b1;
            end
          end
        end
        S_MOVE: begin
          lfsr_q <= lfsr_d;
          if (legal_d) begin
            board_q[~blank_row_q][~blank_col_q] <= board_q[~nbr_row_d][~nbr_col_d];
            board_q[~nbr_row_d][~nbr_col_d]     <= 4'd0;
            blank_row_q  <= nbr_row_d;
            blank_col_q  <= nbr_col_d;
            cnt_q        <= cnt_d;
`ifdef SCRAMBLER_NO_UNDO_EN
            prev_valid_q <= 1'b1;
            prev_dir_q   <= dir_d;
`endif
            if (cnt_d == target_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              start_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_klotski   = board_q;
  assign o_blank_row = blank_row_q;
  assign o_blank_col = blank_col_q;
  assign o_busy      = busy_q;
  assign o_start     = start_q;

endmodule
`default_nettype wire

// File: tb/tb_board_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_scrambler
//  Purpose  : Self-checking bench for board_scrambler against a display-grid
//             reference model of the random blank walk.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_scrambler;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [7:0]           num_moves;
  logic                 seed_load;
  logic [15:0]          seed;
  logic [3:0][3:0][3:0] klotski;
  logic [1:0]           blank_row;
  logic [1:0]           blank_col;
  logic                 busy;
  logic                 start_o;

  int checks = 0;
  int errors = 0;

  // reference model state, display coordinates
  int          m_grid[4][4];
  int          m_br, m_bc, m_prev;
  logic [15:0] m_lfsr;

  board_scrambler #(.LFSR_SEED(16'hACE1), .MAX_MOVES_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_moves(num_moves),
    .i_seed_load(seed_load), .i_seed(seed), .o_klotski(klotski),
    .o_blank_row(blank_row), .o_blank_col(blank_col), .o_busy(busy),
    .o_start(start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_solve();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m_grid[r][c] = (r * 4 + c + 1) % 16;
    m_br = 3; m_bc = 3; m_prev = -1;
  endtask

  task automatic model_seed(input logic [15:0] s);
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  // Random walk from the solved board; k = number of attempts consumed.
  task automatic model_scramble(input int n, output int k);
    int cnt, d, nr, nc;
    bit ok;
    model_solve();
    k = 0; cnt = 0;
    while (cnt < n && k < 60000) begin
      k++;
      d  = int'(m_lfsr[1:0]);
      nr = m_br + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
      nc = m_bc + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
      ok = (nr >= 0) && (nr <= 3) && (nc >= 0) && (nc <= 3);
`ifdef SCRAMBLER_NO_UNDO_EN
      if (m_prev >= 0 && (d ^ 1) == m_prev) ok = 0;
`endif
      if (ok) begin
        m_grid[m_br][m_bc] = m_grid[nr][nc];
        m_grid[nr][nc] = 0;
        m_br = nr; m_bc = nc; m_prev = d; cnt++;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  function automatic logic [3:0][3:0][3:0] model_packed();
    logic [3:0][3:0][3:0] b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[3-r][3-c] = 4'(m_grid[r][c]);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_solve(); m_lfsr = 16'hACE1;
  endtask

  task automatic launch(input int n);
    @(negedge clk); start = 1'b1; num_moves = 8'(n);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk); seed_load = 1'b1; seed = s;
    @(posedge clk); #1 seed_load = 1'b0;
    model_seed(s);
  endtask

  // Watch a scramble until o_start; checks the board invariants every cycle.
  // inject_at > 0 pulses i_start in that cycle (it must be dropped).
  task automatic observe_run(input int budget, input int inject_at, output int lat,
                             output int busy_seen);
    int   cyc, pr, pc, last_dir, dir;
    logic [15:0] seen;
    cyc = 0; lat = -1; busy_seen = 0; pr = 3; pc = 3; last_dir = -1;
    while (cyc < budget && lat < 0) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_at) ? 1'b1 : 1'b0;
      if (cyc == inject_at) num_moves = 8'd3;
      if (busy) busy_seen++;
      seen = '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          seen[klotski[i][j]] = 1'b1;
      checks++;
      if (seen !== 16'hFFFF || klotski[3-blank_row][3-blank_col] !== 4'd0) begin
        errors++;
        $display("FAIL invariant cyc=%0d board=%h blank=(%0d,%0d) seen=%h req=ffff",
                 cyc, klotski, blank_row, blank_col, seen);
      end
      if (int'(blank_row) != pr || int'(blank_col) != pc) begin
        dir = (int'(blank_row) < pr) ? 0 : (int'(blank_row) > pr) ? 1 :
              (int'(blank_col) < pc) ? 2 : 3;
`ifdef SCRAMBLER_NO_UNDO_EN
        checks++;
        if (last_dir >= 0 && (dir ^ 1) == last_dir) begin
          errors++;
          $display("FAIL no_undo cyc=%0d dir=%0d prev=%0d req=not inverse", cyc, dir, last_dir);
        end
`endif
        last_dir = dir;
        pr = int'(blank_row); pc = int'(blank_col);
      end
      if (start_o) lat = cyc;
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout no o_start within %0d cycles req=pulse", budget);
    end
  endtask

  task automatic test_reset();
    logic [3:0][3:0][3:0] exp_b;
    do_reset();
    @(negedge clk);
    exp_b = model_packed();
    checks++;
    if (klotski[0][0] !== 4'd0 || klotski[3][3] !== 4'd1 || klotski[1][0] !== 4'd12) begin
      errors++;
      $display("FAIL reset_cells [0][0]=%0d [3][3]=%0d [1][0]=%0d req 0 1 12",
               klotski[0][0], klotski[3][3], klotski[1][0]);
    end
    checks++;
    if (klotski !== exp_b) begin
      errors++; $display("FAIL reset_board got=%h req=%h", klotski, exp_b);
    end
    checks++;
    if (blank_row !== 2'd3 || blank_col !== 2'd3 || busy !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status blank=(%0d,%0d) busy=%b start=%b req (3,3) 0 0",
               blank_row, blank_col, busy, start_o);
    end
  endtask

  task automatic test_zero_moves();
    int lat, bs, k;
    launch(0);
    model_scramble(0, k);
    observe_run(20, 0, lat, bs);
    checks++;
    if (lat != 1 || bs != 0) begin
      errors++; $display("FAIL zero_moves latency=%0d busy_cycles=%0d req 1 0", lat, bs);
    end
    checks++;
    if (klotski !== model_packed()) begin
      errors++; $display("FAIL zero_moves_board got=%h req=%h", klotski, model_packed());
    end
  endtask

  task automatic test_seed3();
    int lat, bs, k;
    load_seed(16'h0003);
    launch(1);
    model_scramble(1, k);
    observe_run(50, 0, lat, bs);
    checks++;
    if (lat != 4 || k != 3) begin
      errors++; $display("FAIL seed3_latency got=%0d model_k=%0d req 4", lat, k);
    end
    checks++;
    if (klotski[0][0] !== 4'd12 || klotski[1][0] !== 4'd0 || blank_row !== 2'd2 || blank_col !== 2'd3) begin
      errors++;
      $display("FAIL seed3_board [0][0]=%0d [1][0]=%0d blank=(%0d,%0d) req 12 0 (2,3)",
               klotski[0][0], klotski[1][0], blank_row, blank_col);
    end
  endtask

  task automatic test_zero_seed();
    int lat, bs, k;
    logic [3:0][3:0][3:0] first_b;
    do_reset();
    launch(20);
    model_scramble(20, k);
    observe_run(2000, 0, lat, bs);
    first_b = klotski;
    checks++;
    if (klotski !== model_packed() || lat != k + 1) begin
      errors++;
      $display("FAIL post_reset_run got=%h lat=%0d req=%h lat=%0d", klotski, lat, model_packed(), k + 1);
    end
    load_seed(16'h0000);
    launch(20);
    model_scramble(20, k);
    observe_run(2000, 0, lat, bs);
    checks++;
    if (klotski !== first_b) begin
      errors++; $display("FAIL zero_seed got=%h req=%h", klotski, first_b);
    end
  endtask

  task automatic test_random();
    int lat, bs, k, n;
    logic [15:0] s;
    for (int it = 0; it < 8; it++) begin
      s = 16'($urandom);
      if (it == 3) s = 16'h0000;
      n = $urandom_range(1, 60);
      if (it % 2 == 0) begin
        load_seed(s);
        launch(n);
      end else begin
        // seed load and start on the same edge: the seed applies first
        @(negedge clk); seed_load = 1'b1; seed = s; start = 1'b1; num_moves = 8'(n);
        @(posedge clk); #1 seed_load = 1'b0; start = 1'b0;
        model_seed(s);
      end
      model_scramble(n, k);
      observe_run(4000, 0, lat, bs);
      checks++;
      if (klotski !== model_packed() || blank_row !== 2'(m_br) || blank_col !== 2'(m_bc)) begin
        errors++;
        $display("FAIL random_board it=%0d got=%h blank=(%0d,%0d) req=%h (%0d,%0d)",
                 it, klotski, blank_row, blank_col, model_packed(), m_br, m_bc);
      end
      checks++;
      if (lat != k + 1 || bs != k) begin
        errors++;
        $display("FAIL random_latency it=%0d lat=%0d busy=%0d req lat=%0d busy=%0d", it, lat, bs, k + 1, k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bs, k, extra;
    logic [3:0][3:0][3:0] held;
    load_seed(16'h5A5A);
    launch(255);
    model_scramble(255, k);
    observe_run(20000, 40, lat, bs);
    checks++;
    if (lat != k + 1 || klotski !== model_packed()) begin
      errors++;
      $display("FAIL long_run lat=%0d board=%h req lat=%0d board=%h", lat, klotski, k + 1, model_packed());
    end
    // i_start during DONE is dropped; board must stay put afterwards
    start = 1'b1; num_moves = 8'd5;
    @(posedge clk); #1 start = 1'b0;
    held = model_packed();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start_o || busy || klotski !== held) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL done_hold disturbed_cycles=%0d req 0 board=%h", extra, klotski);
    end
  endtask

  task automatic test_reset_mid_move();
    int lat, bs, k, pulses;
    launch(200);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_move_busy got=%b req 1", busy);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (klotski !== model_packed() || blank_row !== 2'd3 || blank_col !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state board=%h blank=(%0d,%0d) busy=%b req=%h (3,3) 0",
               klotski, blank_row, blank_col, busy, model_packed());
    end
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_pulse count=%0d req 0", pulses);
    end
    launch(30);
    model_scramble(30, k);
    observe_run(4000, 0, lat, bs);
    checks++;
    if (klotski !== model_packed() || lat != k + 1) begin
      errors++;
      $display("FAIL after_abort got=%h lat=%0d req=%h lat=%0d", klotski, lat, model_packed(), k + 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_moves = '0; seed_load = 1'b0; seed = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_zero_moves();
    test_seed3();
    test_zero_seed();
    test_random();
    test_back_to_back();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
